// File: rtl/core_pkg.sv
// Shared types for the 16-bit core's instruction fetch path.
package core_pkg;

  localparam int unsigned WordWidth = 16;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [WordWidth-1:0] Word;
    logic [WordWidth-1:0] Address;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO of fetched words tagged with their addresses.
// Flush empties it on the next edge; a push and a pop on a full buffer are both legal.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int unsigned Depth      = 2,
  parameter int unsigned CountWidth = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Push,
  input  fetch_entry_t          PushEntry,
  input  logic                  Pop,
  input  logic                  Flush,
  output fetch_entry_t          HeadEntry,
  output logic                  Empty,
  output logic [CountWidth-1:0] Count
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t        entries [Depth];
  logic [PtrWidth-1:0] read_ptr;
  logic [PtrWidth-1:0] write_ptr;

  function automatic logic [PtrWidth-1:0] advance(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  always_ff @(posedge Clock) begin
    if (Push) begin
      entries[write_ptr] <= PushEntry;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      read_ptr  <= '0;
      write_ptr <= '0;
      Count     <= '0;
    end else begin
      if (Push) begin
        write_ptr <= advance(write_ptr);
      end
      if (Pop) begin
        read_ptr <= advance(read_ptr);
      end
      Count <= Count + CountWidth'(Push) - CountWidth'(Pop);
    end
  end

  always_comb begin
    HeadEntry = entries[read_ptr];
    Empty     = (Count == '0);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch pointer, outstanding/discard accounting and the FETCH/DRAIN redirect FSM
// feeding the decode stage through fetch_buffer.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [WordWidth-1:0] ResetVector  = 16'h0000,
  parameter int unsigned          BufferDepth  = 2,
  parameter int unsigned          CounterWidth = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  output logic                 MemRequestValid,
  input  logic                 MemRequestReady,
  output logic [WordWidth-1:0] MemAddress,
  input  logic                 MemResponseValid,
  input  logic [WordWidth-1:0] MemResponseData,
  output logic                 InstructionValid,
  input  logic                 InstructionReady,
  output logic [WordWidth-1:0] Instruction,
  output logic [WordWidth-1:0] InstructionAddress,
  input  logic                 RedirectValid,
  input  logic [WordWidth-1:0] RedirectAddress,
  output logic                 Busy
);

  localparam logic [CounterWidth:0] DepthLimit = BufferDepth[CounterWidth:0];

  fetch_state_t              state;
  logic [WordWidth-1:0]      fetch_pointer;
  logic [CounterWidth-1:0]   outstanding;
  logic [CounterWidth-1:0]   discard;
  logic [CounterWidth-1:0]   outstanding_next;
  logic [CounterWidth-1:0]   discard_next;
  logic [CounterWidth-1:0]   buffer_count;
  logic [CounterWidth:0]     occupancy;
  logic                      buffer_empty;
  logic                      request_fire;
  logic                      deliver_fire;
  logic                      push;
  fetch_entry_t              push_entry;
  fetch_entry_t              head_entry;

  always_comb begin
    occupancy        = {1'b0, outstanding} + {1'b0, buffer_count};
    MemRequestValid  = !Reset && (state == FETCH) && (occupancy < DepthLimit);
    request_fire     = MemRequestValid && MemRequestReady;
    InstructionValid = !Reset && !buffer_empty;
    deliver_fire     = InstructionValid && InstructionReady;
    push             = MemResponseValid && (state == FETCH) && !RedirectValid;
    outstanding_next = outstanding + CounterWidth'(request_fire) - CounterWidth'(MemResponseValid);
    discard_next     = discard - CounterWidth'(MemResponseValid);
    // Responses return in order and FETCH only ever holds current-path requests,
    // so the oldest outstanding address is the pointer minus the outstanding count.
    push_entry.Word    = MemResponseData;
    push_entry.Address = fetch_pointer - WordWidth'(outstanding);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= FETCH;
      fetch_pointer <= ResetVector;
      outstanding   <= '0;
      discard       <= '0;
    end else begin
      outstanding <= outstanding_next;
      unique case (state)
        FETCH: begin
          if (RedirectValid) begin
            fetch_pointer <= RedirectAddress;
            discard       <= outstanding_next;
            state         <= (outstanding_next != '0) ? DRAIN : FETCH;
          end else if (request_fire) begin
            fetch_pointer <= fetch_pointer + WordWidth'(1);
          end
        end
        DRAIN: begin
          discard <= discard_next;
          if (RedirectValid) begin
            fetch_pointer <= RedirectAddress;
          end
          if (discard_next == '0) begin
            state <= FETCH;
          end
        end
      endcase
    end
  end

  always_comb begin
    MemAddress         = fetch_pointer;
    Busy               = !Reset && (state == DRAIN);
    Instruction        = head_entry.Word;
    InstructionAddress = head_entry.Address;
  end

  fetch_buffer #(
    .Depth      (BufferDepth),
    .CountWidth (CounterWidth)
  ) buffer (
    .Clock     (Clock),
    .Reset     (Reset),
    .Push      (push),
    .PushEntry (push_entry),
    .Pop       (deliver_fire),
    .Flush     (RedirectValid),
    .HeadEntry (head_entry),
    .Empty     (buffer_empty),
    .Count     (buffer_count)
  );

  assert property (@(posedge Clock) disable iff (Reset) MemResponseValid |-> (outstanding != '0));
  assert property (@(posedge Clock) disable iff (Reset) ({1'b0, outstanding} <= DepthLimit));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a queue model of memory, fetch
// order and redirects predicts requests, Busy and the delivered instruction stream.
module tb_fetch_sequencer;
  import core_pkg::*;

  localparam logic [15:0] ResetVec = 16'hFFFF;
  localparam int unsigned Depth    = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        MemRequestValid;
  logic        MemRequestReady = 1'b0;
  logic [15:0] MemAddress;
  logic        MemResponseValid = 1'b0;
  logic [15:0] MemResponseData = '0;
  logic        InstructionValid;
  logic        InstructionReady = 1'b0;
  logic [15:0] Instruction;
  logic [15:0] InstructionAddress;
  logic        RedirectValid = 1'b0;
  logic [15:0] RedirectAddress = '0;
  logic        Busy;

  fetch_sequencer #(
    .ResetVector  (ResetVec),
    .BufferDepth  (Depth),
    .CounterWidth (2)
  ) dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .MemRequestValid    (MemRequestValid),
    .MemRequestReady    (MemRequestReady),
    .MemAddress         (MemAddress),
    .MemResponseValid   (MemResponseValid),
    .MemResponseData    (MemResponseData),
    .InstructionValid   (InstructionValid),
    .InstructionReady   (InstructionReady),
    .Instruction        (Instruction),
    .InstructionAddress (InstructionAddress),
    .RedirectValid      (RedirectValid),
    .RedirectAddress    (RedirectAddress),
    .Busy               (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    int          epoch;
  } pend_t;

  pend_t       pending[$];
  logic [15:0] expq[$];
  int          fifo_words = 0;
  int          epoch      = 0;
  int          req_count  = 0;
  logic [15:0] next_addr  = ResetVec;
  int          compared   = 0;
  int          mismatched = 0;

  int unsigned p_mready = 100;
  int unsigned p_resp   = 100;
  int unsigned p_iready = 100;
  int unsigned p_redir  = 0;
  logic        rst_req      = 1'b1;
  logic        force_redir  = 1'b0;
  logic [15:0] force_target = '0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (pending[i]) if (pending[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    Reset            = rst_req;
    MemRequestReady  = ($urandom_range(99) < p_mready);
    MemResponseValid = !rst_req && (pending.size() > 0) && ($urandom_range(99) < p_resp);
    MemResponseData  = MemResponseValid ? mem_word(pending[0].addr) : 16'($urandom);
    InstructionReady = ($urandom_range(99) < p_iready);
    if (force_redir) begin
      RedirectValid   = 1'b1;
      RedirectAddress = force_target;
      force_redir     = 1'b0;
    end else begin
      RedirectValid = ($urandom_range(99) < p_redir);
      case ($urandom_range(3))
        0:       RedirectAddress = 16'hFFFE;
        1:       RedirectAddress = 16'h0040;
        default: RedirectAddress = 16'($urandom);
      endcase
    end
  endtask

  // Memory, fetch-order and redirect model; samples at negedge, updates after posedge.
  initial begin : model
    logic        c_rst, c_req, c_resp, c_pop, c_redir, prev_rst;
    logic [15:0] c_addr, c_target;
    pend_t       p;
    prev_rst = 1'b0;
    forever begin
      @(negedge Clock);
      c_rst    = Reset;
      c_req    = MemRequestValid && MemRequestReady;
      c_addr   = MemAddress;
      c_resp   = MemResponseValid;
      c_pop    = InstructionValid && InstructionReady;
      c_redir  = RedirectValid;
      c_target = RedirectAddress;
      if (c_rst) begin
        check_bit("rst_req_valid", MemRequestValid, 1'b0);
        check_bit("rst_inst_valid", InstructionValid, 1'b0);
        check_bit("rst_busy", Busy, 1'b0);
        if (prev_rst) check16("rst_mem_address", MemAddress, ResetVec);
      end else begin
        check_bit("req_valid", MemRequestValid,
                  (stale_count() == 0) && (pending.size() + fifo_words < int'(Depth)));
        check_bit("busy", Busy, stale_count() != 0);
        if (c_req) check16("req_address", c_addr, next_addr);
      end
      prev_rst = c_rst;

      @(posedge Clock);
      if (c_rst) begin
        pending.delete();
        expq.delete();
        fifo_words = 0;
        epoch++;
        next_addr = ResetVec;
      end else begin
        if (c_resp && pending.size() > 0) begin
          p = pending.pop_front();
          if (p.epoch == epoch && !c_redir) fifo_words++;
        end
        if (c_pop && fifo_words > 0) fifo_words--;
        if (c_req) begin
          req_count++;
          pending.push_back('{addr: c_addr, epoch: epoch});
          if (!c_redir) begin
            expq.push_back(c_addr);
            next_addr = c_addr + 16'd1;
          end
        end
        if (c_redir) begin
          epoch++;
          expq.delete();
          fifo_words = 0;
          next_addr  = c_target;
        end
      end
      #1 drive();
    end
  end

  // Delivery monitor: every valid head is compared against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        check_bit("inst_valid", InstructionValid, fifo_words != 0);
        if (InstructionValid) begin
          if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL inst_unexpected: got address %h, want no instruction", InstructionAddress);
          end else begin
            check16("inst_address", InstructionAddress, expq[0]);
            check16("inst_data", Instruction, mem_word(expq[0]));
            if (InstructionReady) void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge Clock);
  endtask

  initial begin : main
    // Always-ready memory: requests FFFF, 0000, ... and in-order delivery.
    cycles(4);
    rst_req = 1'b0;
    cycles(20);

    // Decode stalled: exactly Depth requests, then the head word is held.
    rst_req  = 1'b1;
    p_iready = 0;
    cycles(3);
    req_count = 0;
    rst_req   = 1'b0;
    cycles(12);
    #2;
    check16("stall_request_count", 16'(req_count), 16'(Depth));
    check_bit("stall_request_low", MemRequestValid, 1'b0);
    p_iready = 100;
    cycles(10);

    // Redirect to 0x0040 with two requests outstanding.
    rst_req = 1'b1;
    cycles(3);
    p_resp  = 0;
    rst_req = 1'b0;
    cycles(6);
    #2;
    check_bit("outstanding_full_req_low", MemRequestValid, 1'b0);
    force_target = 16'h0040;
    force_redir  = 1'b1;
    cycles(2);
    #2;
    check_bit("redirect_busy", Busy, 1'b1);
    p_resp = 100;
    cycles(15);

    // Redirect in steady streaming, typically alongside a request and a response.
    cycles(7);
    force_target = 16'h1230;
    force_redir  = 1'b1;
    cycles(15);

    // Reset with a full buffer, then restart from the reset vector.
    p_iready = 0;
    cycles(10);
    rst_req = 1'b1;
    cycles(3);
    p_iready = 100;
    rst_req  = 1'b0;
    cycles(15);

    // Randomized traffic with occasional resets.
    for (int unsigned r = 0; r < 12; r++) begin
      p_mready = $urandom_range(100, 20);
      p_resp   = $urandom_range(100, 10);
      p_iready = $urandom_range(100, 10);
      p_redir  = $urandom_range(15, 0);
      cycles(250);
      if (r % 4 == 3) begin
        rst_req = 1'b1;
        cycles(2);
        rst_req = 1'b0;
      end
    end

    // Drain everything still in flight.
    p_redir  = 0;
    p_mready = 0;
    p_resp   = 100;
    p_iready = 100;
    for (int unsigned i = 0; i < 100 && (pending.size() != 0 || expq.size() != 0); i++) cycles(1);
    compared++;
    if (pending.size() != 0 || expq.size() != 0) begin
      mismatched++;
      $display("FAIL final_drain: got %0d words undelivered, want 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction supply for the 16-bit core.
- Owns the fetch pointer and issues word-addressed requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents one instruction per handshake to the core's decode stage.
- Handles jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- ResetVector, 16'h0000: fetch address loaded on reset.
- BufferDepth, 2: instruction FIFO entries (2..4). Also caps outstanding+buffered words.
- CounterWidth, 2: width of the outstanding/discard counters. Must hold BufferDepth.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- MemRequestValid  output  1  fetch request valid.
- MemRequestReady  input  1  memory accepts request.
- MemAddress  output  16  word address of request.
- MemResponseValid  input  1  in-order response, no backpressure.
- MemResponseData  input  16  fetched instruction word.
- InstructionValid  output  1  Instruction holds a valid word.
- InstructionReady  input  1  core consumes Instruction.
- Instruction  output  16  FIFO head word.
- InstructionAddress  output  16  address of FIFO head word.
- RedirectValid  input  1  jump taken this cycle.
- RedirectAddress  input  16  jump target.
- Busy  output  1  high while state is DRAIN.

Behaviour:
- Reset:
  - FetchPointer = ResetVector; Outstanding = 0; Discard = 0; FIFO empty; state = FETCH.
  - MemRequestValid, InstructionValid and Busy are 0 in the reset cycle.
  - MemAddress = ResetVector.
- Clock and reset: single Clock domain. Reset is synchronous and active-high. Reset asserted mid-operation abandons all state; responses arriving after reset for pre-reset requests are not tracked and must not occur (memory is reset with the core).
- States (fetch_state_t):
  - FETCH: normal fetching.
  - DRAIN: discarding responses to requests issued before a redirect.
- Request rule:
  - In FETCH, MemRequestValid = (Outstanding + FIFO count) < BufferDepth.
  - MemAddress = FetchPointer.
  - On MemRequestValid & MemRequestReady: FetchPointer += 1 (wraps 16'hFFFF -> 16'h0000) and Outstanding += 1.
  - MemRequestValid is 0 in DRAIN.
- Response rule:
  - In FETCH, a MemResponseValid word is pushed with its address; Outstanding -= 1.
  - The pushed word is visible at the FIFO head no earlier than the next cycle (no bypass).
  - Minimum latency: request accepted cycle N, response N+1, InstructionValid N+2.
- Delivery rule:
  - InstructionValid = FIFO not empty.
  - Instruction/InstructionAddress = head entry; values are held stable while valid and not ready.
  - Pop on InstructionValid & InstructionReady.
- Redirect, any state:
  - FIFO cleared next cycle. A handshake completing in the same cycle still counts as consumed.
  - FetchPointer <= RedirectAddress.
  - Discard <= Outstanding after this cycle's updates: include a request accepted this cycle; exclude a response arriving this cycle, which is dropped.
  - Next state = DRAIN if that Discard > 0, else FETCH.
  - A request handshake in the redirect cycle still consumes the old address.
- DRAIN:
  - Each MemResponseValid decrements Discard and Outstanding; data is dropped.
  - Leave to FETCH in the cycle after Discard reaches 0.
  - A further redirect in DRAIN replaces FetchPointer and keeps the current Discard count.
- FIFO full:
  - No request is issued when Outstanding + count = BufferDepth. This guarantees no overflow, since responses cannot be back-pressured.
  - A push and a pop in the same cycle on a full FIFO are both legal.
- Assertions:
  - Response with Outstanding = 0 is an error.
  - Outstanding must never exceed BufferDepth.

Decomposition:
- core_pkg holds:
  - WordWidth = 16.
  - fetch_state_t enum {FETCH, DRAIN}.
  - fetch_entry_t struct {Word, Address}.
- Sub-module fetch_buffer: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush/count, synchronous active-high reset on Clock/Reset.
- The top level holds only the pointer, counters and FSM.

Test Plan:
- Reset release, memory always ready with 1-cycle response:
  - Expect requests at 0x0000, 0x0001, …
  - InstructionValid 2 cycles after the first request.
  - Words delivered in order with InstructionAddress 0x0000, 0x0001.
- InstructionReady held 0 with BufferDepth=2:
  - Exactly 2 requests issued, then MemRequestValid stays 0.
  - Instruction stays 0x0000's word until ready rises.
- Redirect to 0x0040 while 2 requests are outstanding:
  - Busy=1, both responses dropped.
  - Next request is 0x0040; first delivered address is 0x0040.
- Redirect in the same cycle as a response and a request handshake:
  - Response dropped; Discard=1.
  - Next delivered address is the redirect target.
- ResetVector=16'hFFFF:
  - Requests 0xFFFF then 0x0000 (wrap).
  - Delivered addresses match.
- Reset asserted with FIFO full and Busy=1:
  - Next cycle all outputs are at reset values.
  - Fetching restarts at ResetVector.
